// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_pkg
// Description : Shared encodings for the store unit: access sizes, completion
//               status codes and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_mux
// Description : Narrows a register value to the access size and replicates it
//               across the byte lanes, producing matching byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_mux
    import store_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misaligned
);

    always_comb begin
        o_wdata      = '0;
        o_be         = '0;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_wdata      = {2{i_data[15:0]}};
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_wdata      = i_data;
                o_be         = 4'b1111;
                o_misaligned = |i_addr_lo;
            end
            // Reserved size is reported separately by the controller.
            default: begin
                o_wdata      = '0;
                o_be         = '0;
                o_misaligned = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_unit
// Description : Issues one lane-aligned memory write per start over a req/ack
//               handshake and reports completion status with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);
    import store_pkg::*;

    localparam bit                   c_timeout_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [1:0]           r_err, w_err_nxt;
    logic                 r_req, w_req_nxt;
    logic [31:0]          r_addr, w_addr_nxt;
    logic [31:0]          r_wdata, w_wdata_nxt;
    logic [3:0]           r_be, w_be_nxt;

    logic [31:0]          w_lane_wdata;
    logic [3:0]           w_lane_be;
    logic                 w_lane_misaligned;

    store_lane_mux u_lane_mux (
        .i_size       (size),
        .i_addr_lo    (addr[1:0]),
        .i_data       (store_data),
        .o_wdata      (w_lane_wdata),
        .o_be         (w_lane_be),
        .o_misaligned (w_lane_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_be    <= w_be_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (size == SZ_RSVD) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = ERR_SIZE;
                    end else if (w_lane_misaligned) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = ERR_MISALIGN;
                    end else begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_addr_nxt  = {addr[31:2], 2'b00};
                        w_wdata_nxt = w_lane_wdata;
                        w_be_nxt    = w_lane_be;
                    end
                end
            end
            REQ: begin
                // Ack is tested first so it wins over a timeout on the same edge.
                if (mem_ack) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = ERR_OK;
                    w_req_nxt   = 1'b0;
                end else if (c_timeout_en && (r_cnt == c_timeout_last)) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = ERR_TIMEOUT;
                    w_req_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err;
    assign mem_req   = r_req;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule
`default_nettype wire

// File: doc/store_unit.md
Name: store_unit

Overview:
- Inverse of the load-side sign extender: narrows a 32-bit register value to byte/halfword/word and places it on the correct byte lanes of a 32-bit word-addressed data memory.
- Issues one write transaction per start over a req/ack handshake.
- Sits between the multicycle control FSM (MEM state) and the data memory port.
- Reports completion and error status back to control.

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited in REQ for mem_ack before aborting; 0 disables the timeout.
- CNT_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin store; sampled only in IDLE.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- addr  input  32  byte address.
- store_data  input  32  register value; low bits are used for byte/half.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err_code  output  2  valid with done: 00 ok, 01 misaligned, 10 bad size, 11 timeout.
- mem_req  output  1  write request, held until ack.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit i enables bits [8i+7:8i].
- mem_ack  input  1  memory accepted the write this cycle.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered.
- On reset at a clock edge: state=IDLE; busy, done, mem_req=0; err_code, mem_addr, mem_wdata, mem_be, counter=0.
- Reset mid-transaction: the transaction is abandoned with no done pulse, and mem_req drops at that edge.
- States: IDLE, REQ, DONE.
- IDLE, start=1 at edge:
  - Capture addr/size/store_data.
  - If size=11: go to DONE, err=10.
  - Else if misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to DONE, err=01.
  - Misaligned or bad-size stores never assert mem_req.
  - Otherwise: go to REQ, load mem_addr/mem_wdata/mem_be, mem_req=1, counter=0.
- IDLE, start=0: stay; mem_ack is ignored.
- REQ:
  - mem_req and its address/data/enables are held stable until ack.
  - mem_ack=1 at edge: go to DONE, err=00, mem_req=0.
  - Otherwise counter++. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE, err=11, mem_req=0.
  - If ack and timeout fall on the same edge, ack wins (err=00).
- DONE: done=1 for exactly one cycle with err_code valid, then IDLE. start is ignored in REQ and DONE, with no queuing.
- err_code holds its last value until the next done.
- Lane placement:
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - Half: wdata={2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata=d, be=1111.
  - Upper bits of store_data are discarded (truncation, no range check).
- Latency:
  - start at cycle 0; mem_req high in cycle 1.
  - With ack in cycle k, done is high in cycle k+1; minimum start-to-done is 2 cycles.
  - Error path: done in cycle 1.
  - Back-to-back: the next start is accepted in the cycle after done.

Decomposition:
- Package store_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - error codes ERR_OK/ERR_MISALIGN/ERR_SIZE/ERR_TIMEOUT;
  - the state enum IDLE/REQ/DONE.
- One combinational sub-module, store_lane_mux (size, addr[1:0], data -> wdata, be, misaligned).
- The FSM and timeout counter stay in store_unit.

Test Plan:
- Byte store: size=00, addr=0x0000_1003, data=0xDEAD_BEEF, ack immediate -> mem_addr=0x0000_1000, be=1000, wdata=0xEFEF_EFEF; done cycle 2, err=00.
- Half store: size=01, addr=0x0000_2002, data=0x1234_ABCD, ack after 3 cycles -> be=1100, wdata=0xABCD_ABCD; mem_req held 4 cycles with stable address/data/enables; then done, err=00.
- Misaligned word: size=10, addr=0x0000_0006 -> mem_req never high; done in cycle 1, err=01. Repeat with size=11 -> err=10.
- Timeout: TIMEOUT_CYCLES=4, mem_ack tied 0 -> mem_req high 4 cycles then drops; done with err=11. Ack and timeout on the same edge -> err=00.
- Reset while in REQ -> next edge: mem_req=0, busy=0, no done pulse. A subsequent word store to 0x10 completes normally with be=1111.
- Back-to-back: start held high continuously -> start ignored while busy; the second transaction starts the cycle after done.
